// File: rtl/writeback_arbiter.sv
// Merges single-cycle ALU results and buffered load results onto one register file write port.
// ALU has priority; a starvation counter forces a load grant after a run of ALU grants.
module writeback_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            alu_valid,
    output logic                            alu_ready,
    input  logic [ADDR_W-1:0]               alu_rd,
    input  logic [DATA_W-1:0]               alu_data,
    input  logic                            mem_valid,
    output logic                            mem_ready,
    input  logic [ADDR_W-1:0]               mem_rd,
    input  logic [DATA_W-1:0]               mem_data,
    output logic                            writeEnable,
    output logic [ADDR_W-1:0]               writeAddr,
    output logic [DATA_W-1:0]               writeData,
    output logic [$clog2(FIFO_DEPTH):0]     pending
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
    localparam int ENT_W = ADDR_W + DATA_W;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [SC_W-1:0]  LIMIT_CNT = SC_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_ALU,
        GRANT_FIFO
    } grant_t;

    logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [SC_W-1:0]   starve_reg;
    logic              force_reg;

    grant_t            grant;
    logic              fifo_nonempty;
    logic              push, pop;
    logic [ADDR_W-1:0] head_rd, grant_rd;
    logic [DATA_W-1:0] head_data, grant_data;
    logic [SC_W-1:0]   starve_next;

    assign fifo_nonempty = (count_reg != '0);
    assign {head_rd, head_data} = fifo_mem[rd_ptr_reg];
    assign starve_next = starve_reg + 1'b1;

    always_comb begin
        grant      = GRANT_NONE;
        grant_rd   = '0;
        grant_data = '0;
        if (force_reg && fifo_nonempty) begin
            grant = GRANT_FIFO;
        end else if (alu_valid) begin
            grant = GRANT_ALU;
        end else if (fifo_nonempty) begin
            grant = GRANT_FIFO;
        end
        if (grant == GRANT_FIFO) begin
            grant_rd   = head_rd;
            grant_data = head_data;
        end else if (grant == GRANT_ALU) begin
            grant_rd   = alu_rd;
            grant_data = alu_data;
        end
    end

    // A full FIFO refuses new loads this cycle even if it pops; space shows up next cycle.
    assign alu_ready = !rst && !(force_reg && fifo_nonempty);
    assign mem_ready = !rst && (count_reg < FULL_CNT);
    assign push      = mem_valid && mem_ready;
    assign pop       = (grant == GRANT_FIFO);
    assign pending   = count_reg;

    // Storage carries no reset; flushing the pointers discards any stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {mem_rd, mem_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_reg <= '0;
            force_reg  <= 1'b0;
        end else if (!fifo_nonempty || pop) begin
            starve_reg <= '0;
            force_reg  <= 1'b0;
        end else if (grant == GRANT_ALU) begin
            starve_reg <= starve_next;
            if (starve_next == LIMIT_CNT) begin
                force_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            writeEnable <= 1'b0;
            writeAddr   <= '0;
            writeData   <= '0;
        end else begin
            writeEnable <= (grant != GRANT_NONE) && (grant_rd != '0);
            if (grant != GRANT_NONE) begin
                writeAddr <= grant_rd;
                writeData <= grant_data;
            end
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized scoreboard bench: a queue-based reference model predicts every cycle's write port
// contents and handshakes; a separate monitor pops predictions and compares after each edge.
module tb_writeback_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid, alu_ready;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          mem_valid, mem_ready;
    logic [AW-1:0] mem_rd;
    logic [DW-1:0] mem_data;
    logic          writeEnable;
    logic [AW-1:0] writeAddr;
    logic [DW-1:0] writeData;
    logic [2:0]    pending;

    writeback_arbiter #(
        .DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .writeEnable(writeEnable), .writeAddr(writeAddr), .writeData(writeData),
        .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    wr_t  exp_q[$];
    ent_t load_q[$];
    int   checks = 0;
    int   passed = 0;
    int   model_starve = 0;
    bit   model_force = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_data = '0;
    wr_t  mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: one prediction per cycle, compared just after the edge that produced it.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("writeEnable", 64'(writeEnable), 64'(mon_e.we));
                check("writeAddr", 64'(writeAddr), 64'(mon_e.addr));
                check("writeData", 64'(writeData), 64'(mon_e.data));
                if (mon_e.we) $display("write rd=%0d data=%h t=%0t", mon_e.addr, mon_e.data, $time);
            end
        end
    end

    task automatic do_cycle(input bit do_rst, input int pa, input int pm);
        int   sz;
        bit   ne, fg, ag;
        wr_t  w;
        ent_t h;
        @(posedge clk);
        #2;
        if (do_rst) begin
            rst       = 1'b1;
            alu_valid = 1'b0;
            mem_valid = 1'b0;
            #1;
            check("rst_writeEnable", 64'(writeEnable), 64'd0);
            check("rst_writeAddr", 64'(writeAddr), 64'd0);
            check("rst_pending", 64'(pending), 64'd0);
            check("rst_alu_ready", 64'(alu_ready), 64'd0);
            check("rst_mem_ready", 64'(mem_ready), 64'd0);
            load_q.delete();
            exp_q.delete();
            model_starve = 0;
            model_force  = 1'b0;
            last_addr    = '0;
            last_data    = '0;
            exp_q.push_back('{1'b0, {AW{1'b0}}, {DW{1'b0}}});
        end else begin
            rst       = 1'b0;
            alu_valid = ($urandom_range(99) < pa);
            alu_rd    = ($urandom_range(7) == 0) ? '0 : AW'($urandom_range(31));
            alu_data  = $urandom;
            mem_valid = ($urandom_range(99) < pm);
            mem_rd    = ($urandom_range(7) == 0) ? '0 : AW'($urandom_range(31));
            mem_data  = $urandom;
            #1;
            sz = load_q.size();
            ne = (sz > 0);
            fg = ne && (model_force || !alu_valid);
            ag = alu_valid && !fg;
            check("alu_ready", 64'(alu_ready), 64'(!(model_force && ne)));
            check("mem_ready", 64'(mem_ready), 64'(sz < DEPTH));
            check("pending", 64'(pending), 64'(sz));
            w = '{1'b0, last_addr, last_data};
            if (fg) begin
                h = load_q.pop_front();
                w = '{(h.rd != 0), h.rd, h.data};
            end else if (ag) begin
                w = '{(alu_rd != 0), alu_rd, alu_data};
            end
            last_addr = w.addr;
            last_data = w.data;
            exp_q.push_back(w);
            if (mem_valid && sz < DEPTH) load_q.push_back('{mem_rd, mem_data});
            if (fg || !ne) begin
                model_starve = 0;
                model_force  = 1'b0;
            end else if (ag) begin
                model_starve++;
                if (model_starve >= LIMIT) model_force = 1'b1;
            end
        end
    endtask

    initial begin
        int  phase, pa, pm;
        bit  r;
        rst       = 1'b1;
        alu_valid = 1'b0;
        alu_rd    = '0;
        alu_data  = '0;
        mem_valid = 1'b0;
        mem_rd    = '0;
        mem_data  = '0;
        for (int c = 0; c < 900; c++) begin
            phase = (c / 100) % 3;
            pa = (phase == 0) ? 50 : (phase == 1) ? 100 : 20;
            pm = (phase == 0) ? 50 : (phase == 1) ? 70 : 40;
            r  = (c < 2) || (c == 150) || (c == 151) || (c == 450) || (c == 720);
            do_cycle(r, pa, pm);
        end
        for (int c = 0; c < 30; c++) do_cycle(1'b0, 0, 0);
        @(posedge clk);
        #2;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
